// File: rtl/core_mem_stage.sv
// MEM pipeline stage: data-memory req/gnt/rvalid sequencing, load align/extend, store lane generation, MEM/WB register.
// Optional misaligned-access trap enabled by defining CORE_MEM_MISALIGN_TRAP_EN (adds misalign_o).
module core_mem_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        mem_to_reg_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   pc_plus_4_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              reg_write_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [1:0]        wb_mem_to_reg_o,
  output logic [XLEN-1:0]   wb_dmem_rd_data_o,
  output logic [XLEN-1:0]   wb_imm_o,
  output logic [XLEN-1:0]   wb_pc_plus_4_o,
  output logic [XLEN-1:0]   wb_alu_result_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic              wb_reg_write_o
`ifdef CORE_MEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

  state_t            state;
  logic [1:0]        off;
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              mis;
  logic              mem_op;
  logic              store;
  logic              complete;
  logic              capture;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_data;
  logic [XLEN/8-1:0] st_be;
  logic [XLEN-1:0]   st_wdata;

  assign off     = alu_result_i[1:0];
  assign is_byte = (funct3_i[1:0] == 2'b00);
  assign is_half = (funct3_i[1:0] == 2'b01);
  assign is_word = ~is_byte & ~is_half;
  assign store   = mem_write_i;

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  assign mis = valid_i & (mem_read_i | mem_write_i) &
               ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  // A trapped access is not a memory op: it never requests or stalls.
  assign mem_op     = valid_i & (mem_read_i | mem_write_i) & ~mis;
  assign dmem_req_o = mem_op & (state != WAIT_RVALID);
  assign complete   = mem_op & ((dmem_req_o & dmem_gnt_i & store) |
                                ((state == WAIT_RVALID) & dmem_rvalid_i));
  assign stall_o    = mem_op & ~complete;
  assign capture    = valid_i & ~stall_o;

  assign dmem_addr_o  = {alu_result_i[XLEN-1:2], 2'b00};
  assign dmem_we_o    = dmem_req_o & store;
  assign dmem_be_o    = dmem_we_o ? st_be : '0;
  assign dmem_wdata_o = st_wdata;

  always_comb begin
    st_be    = '1;
    st_wdata = rs2_data_i;
    if (is_byte) begin
      st_be    = 4'b0001 << off;
      st_wdata = {4{rs2_data_i[7:0]}};
    end else if (is_half) begin
      st_be    = off[1] ? 4'b1100 : 4'b0011;
      st_wdata = {2{rs2_data_i[15:0]}};
    end
  end

  assign ld_byte = dmem_rdata_i[{off, 3'b000} +: 8];
  assign ld_half = dmem_rdata_i[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = dmem_rdata_i;
    case (funct3_i)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op && !dmem_gnt_i)
            state <= WAIT_GNT;
          else if (mem_op && dmem_gnt_i && !store)
            state <= WAIT_RVALID;
        end
        WAIT_GNT: begin
          if (!mem_op)
            state <= IDLE;
          else if (dmem_gnt_i)
            state <= store ? IDLE : WAIT_RVALID;
        end
        WAIT_RVALID: begin
          if (dmem_rvalid_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bubbles clear only valid/reg_write; payload fields keep their last captured values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_valid_o        <= 1'b0;
      wb_mem_to_reg_o   <= '0;
      wb_dmem_rd_data_o <= '0;
      wb_imm_o          <= '0;
      wb_pc_plus_4_o    <= '0;
      wb_alu_result_o   <= '0;
      wb_rd_addr_o      <= '0;
      wb_reg_write_o    <= 1'b0;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
      misalign_o        <= 1'b0;
`endif
    end else if (capture) begin
      wb_valid_o        <= 1'b1;
      wb_mem_to_reg_o   <= mem_to_reg_i;
      wb_dmem_rd_data_o <= ld_data;
      wb_imm_o          <= imm_i;
      wb_pc_plus_4_o    <= pc_plus_4_i;
      wb_alu_result_o   <= alu_result_i;
      wb_rd_addr_o      <= rd_addr_i;
      wb_reg_write_o    <= reg_write_i & ~mis;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
      misalign_o        <= mis;
`endif
    end else begin
      wb_valid_o        <= 1'b0;
      wb_reg_write_o    <= 1'b0;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
      misalign_o        <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_core_mem_stage.sv
// Directed self-checking bench for core_mem_stage; misalign test compiled only with CORE_MEM_MISALIGN_TRAP_EN.
module tb_core_mem_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        valid_i;
  logic [31:0] alu_result_i;
  logic [31:0] rs2_data_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [1:0]  mem_to_reg_i;
  logic [31:0] imm_i;
  logic [31:0] pc_plus_4_i;
  logic [4:0]  rd_addr_i;
  logic        reg_write_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [1:0]  wb_mem_to_reg_o;
  logic [31:0] wb_dmem_rd_data_o;
  logic [31:0] wb_imm_o;
  logic [31:0] wb_pc_plus_4_o;
  logic [31:0] wb_alu_result_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_reg_write_o;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  core_mem_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .alu_result_i(alu_result_i),
    .rs2_data_i(rs2_data_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .mem_to_reg_i(mem_to_reg_i), .imm_i(imm_i),
    .pc_plus_4_i(pc_plus_4_i), .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_mem_to_reg_o(wb_mem_to_reg_o),
    .wb_dmem_rd_data_o(wb_dmem_rd_data_o), .wb_imm_o(wb_imm_o),
    .wb_pc_plus_4_o(wb_pc_plus_4_o), .wb_alu_result_o(wb_alu_result_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_reg_write_o(wb_reg_write_o)
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rda, input logic rw);
    valid_i      = v;
    mem_read_i   = rd;
    mem_write_i  = wr;
    funct3_i     = f3;
    alu_result_i = addr;
    rs2_data_i   = rs2;
    rd_addr_i    = rda;
    reg_write_i  = rw;
    mem_to_reg_i = {rd, 1'b0};
    imm_i        = addr + 32'd1;
    pc_plus_4_i  = addr + 32'd4;
  endtask

  task automatic go_idle();
    @(negedge clk_i);
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    #2;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0h exp=0", wb_valid_o); end total++;
    if (wb_reg_write_o !== 1'b0) begin bad++; $display("FAIL rst_wb_reg_write got=%0h exp=0", wb_reg_write_o); end total++;
    if ({wb_alu_result_o, wb_dmem_rd_data_o, wb_imm_o, wb_pc_plus_4_o} !== 128'h0) begin bad++; $display("FAIL rst_wb_fields got=%0h exp=0", {wb_alu_result_o, wb_dmem_rd_data_o, wb_imm_o, wb_pc_plus_4_o}); end total++;
    if ({dmem_req_o, dmem_we_o, stall_o} !== 3'b000) begin bad++; $display("FAIL rst_req_we_stall got=%0b exp=000", {dmem_req_o, dmem_we_o, stall_o}); end total++;
    @(negedge clk_i); @(negedge clk_i);
    rstn_i = 1'b1;
  endtask

  task automatic test_lb(input logic [2:0] f3, input logic [31:0] exp);
    @(negedge clk_i);
    set_op(1'b1, 1'b1, 1'b0, f3, 32'h0000_0103, 32'h0, 5'd5, 1'b1);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
    #1;
    if (dmem_req_o !== 1'b1) begin bad++; $display("FAIL lb_req got=%0h exp=1", dmem_req_o); end total++;
    if (stall_o !== 1'b1) begin bad++; $display("FAIL lb_stall_c0 got=%0h exp=1", stall_o); end total++;
    if (dmem_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL lb_addr got=%0h exp=100", dmem_addr_o); end total++;
    if ({dmem_we_o, dmem_be_o} !== 5'b0) begin bad++; $display("FAIL lb_we_be got=%0b exp=00000", {dmem_we_o, dmem_be_o}); end total++;
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL lb_wb_early got=%0h exp=0", wb_valid_o); end total++;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_0000;
    #1;
    if ({dmem_req_o, stall_o} !== 2'b00) begin bad++; $display("FAIL lb_c1_req_stall got=%0b exp=00", {dmem_req_o, stall_o}); end total++;
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL lb_wb_valid got=%0h exp=1", wb_valid_o); end total++;
    if (wb_dmem_rd_data_o !== exp) begin bad++; $display("FAIL lb_data got=%0h exp=%0h", wb_dmem_rd_data_o, exp); end total++;
    if (wb_rd_addr_o !== 5'd5 || wb_reg_write_o !== 1'b1) begin bad++; $display("FAIL lb_rd_rw got=%0d/%0h exp=5/1", wb_rd_addr_o, wb_reg_write_o); end total++;
    go_idle();
  endtask

  task automatic test_sh_delayed_gnt();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (i == 0) set_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 1'b0);
      dmem_gnt_i = (i == 3);
      #1;
      if ({dmem_req_o, dmem_we_o} !== 2'b11) begin bad++; $display("FAIL sh_req_we c%0d got=%0b exp=11", i, {dmem_req_o, dmem_we_o}); end total++;
      if (dmem_addr_o !== 32'h0000_0200 || dmem_be_o !== 4'b1100) begin bad++; $display("FAIL sh_addr_be c%0d got=%0h/%0b exp=200/1100", i, dmem_addr_o, dmem_be_o); end total++;
      if (dmem_wdata_o !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata c%0d got=%0h exp=abcdabcd", i, dmem_wdata_o); end total++;
      if (stall_o !== (i < 3)) begin bad++; $display("FAIL sh_stall c%0d got=%0h exp=%0h", i, stall_o, (i < 3)); end total++;
      @(posedge clk_i); #1;
      if (wb_valid_o !== (i == 3)) begin bad++; $display("FAIL sh_wb_valid c%0d got=%0h exp=%0h", i, wb_valid_o, (i == 3)); end total++;
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    set_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0011, 32'h0, 5'd1, 1'b1);
    #1;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_add_stall got=%0h exp=0", stall_o); end total++;
    @(posedge clk_i); #1;
    if ({wb_valid_o, wb_reg_write_o, wb_rd_addr_o} !== {2'b11, 5'd1}) begin bad++; $display("FAIL b2b_add1_wb got=%0h/%0h/%0d exp=1/1/1", wb_valid_o, wb_reg_write_o, wb_rd_addr_o); end total++;
    if (wb_alu_result_o !== 32'h11 || wb_pc_plus_4_o !== 32'h15) begin bad++; $display("FAIL b2b_add1_fields got=%0h/%0h exp=11/15", wb_alu_result_o, wb_pc_plus_4_o); end total++;
    @(negedge clk_i);
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd2, 1'b1);
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    if ({wb_valid_o, wb_reg_write_o} !== 2'b00) begin bad++; $display("FAIL b2b_bubble1 got=%0b exp=00", {wb_valid_o, wb_reg_write_o}); end total++;
    if (wb_rd_addr_o !== 5'd1 || wb_alu_result_o !== 32'h11) begin bad++; $display("FAIL b2b_bubble_hold got=%0d/%0h exp=1/11", wb_rd_addr_o, wb_alu_result_o); end total++;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    #1;
    if ({dmem_req_o, stall_o} !== 2'b01) begin bad++; $display("FAIL b2b_wait_rv got=%0b exp=01", {dmem_req_o, stall_o}); end total++;
    @(posedge clk_i); #1;
    if ({wb_valid_o, wb_reg_write_o} !== 2'b00) begin bad++; $display("FAIL b2b_bubble2 got=%0b exp=00", {wb_valid_o, wb_reg_write_o}); end total++;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    if ({wb_valid_o, wb_reg_write_o, wb_rd_addr_o} !== {2'b11, 5'd2}) begin bad++; $display("FAIL b2b_lw_wb got=%0h/%0h/%0d exp=1/1/2", wb_valid_o, wb_reg_write_o, wb_rd_addr_o); end total++;
    if (wb_dmem_rd_data_o !== 32'hDEAD_BEEF || wb_mem_to_reg_o !== 2'b10) begin bad++; $display("FAIL b2b_lw_data got=%0h/%0b exp=deadbeef/10", wb_dmem_rd_data_o, wb_mem_to_reg_o); end total++;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    set_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0033, 32'h0, 5'd3, 1'b1);
    @(posedge clk_i); #1;
    if ({wb_valid_o, wb_rd_addr_o} !== {1'b1, 5'd3} || wb_alu_result_o !== 32'h33) begin bad++; $display("FAIL b2b_add2_wb got=%0h/%0d/%0h exp=1/3/33", wb_valid_o, wb_rd_addr_o, wb_alu_result_o); end total++;
    go_idle();
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%0h exp=0", wb_valid_o); end total++;
  endtask

  task automatic test_store_priority_and_sb();
    @(negedge clk_i);
    set_op(1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h55AA_55AA, 5'd0, 1'b0);
    dmem_gnt_i = 1'b1;
    #1;
    if ({dmem_req_o, dmem_we_o, dmem_be_o} !== 6'b11_1111) begin bad++; $display("FAIL rw_req_we_be got=%0b exp=111111", {dmem_req_o, dmem_we_o, dmem_be_o}); end total++;
    if (dmem_wdata_o !== 32'h55AA_55AA || stall_o !== 1'b0) begin bad++; $display("FAIL rw_wdata_stall got=%0h/%0h exp=55aa55aa/0", dmem_wdata_o, stall_o); end total++;
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b1) begin bad++; $display("FAIL rw_wb_valid got=%0h exp=1", wb_valid_o); end total++;
    @(negedge clk_i);
    set_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 5'd0, 1'b0);
    #1;
    if (dmem_be_o !== 4'b0010 || dmem_wdata_o !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_be_wdata got=%0b/%0h exp=0010/a5a5a5a5", dmem_be_o, dmem_wdata_o); end total++;
    go_idle();
  endtask

`ifndef CORE_MEM_MISALIGN_TRAP_EN
  task automatic test_lh_truncate();
    @(negedge clk_i);
    set_op(1'b1, 1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0, 5'd7, 1'b1);
    dmem_gnt_i = 1'b1;
    #1;
    if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h0) begin bad++; $display("FAIL lh_req_addr got=%0h/%0h exp=1/0", dmem_req_o, dmem_addr_o); end total++;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_7FFF;
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b1 || wb_dmem_rd_data_o !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_data got=%0h/%0h exp=1/ffff8001", wb_valid_o, wb_dmem_rd_data_o); end total++;
    go_idle();
  endtask
`endif

  task automatic test_reset_mid_access();
    @(negedge clk_i);
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd9, 1'b1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    rstn_i = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    dmem_gnt_i = 1'b0;
    #1;
    if (wb_valid_o !== 1'b0 || wb_alu_result_o !== 32'h0 || wb_rd_addr_o !== 5'd0) begin bad++; $display("FAIL mid_rst_wb got=%0h/%0h/%0d exp=0/0/0", wb_valid_o, wb_alu_result_o, wb_rd_addr_o); end total++;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_stale got=%0h exp=0", wb_valid_o); end total++;
    @(negedge clk_i);
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0084, 32'h0, 5'd10, 1'b1);
    #1;
    if ({dmem_req_o, stall_o} !== 2'b11) begin bad++; $display("FAIL mid_rst_idle_req got=%0b exp=11", {dmem_req_o, stall_o}); end total++;
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_rv_in_gnt got=%0h exp=0", wb_valid_o); end total++;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1122_3344;
    @(posedge clk_i); #1;
    if (wb_valid_o !== 1'b1 || wb_dmem_rd_data_o !== 32'h1122_3344 || wb_rd_addr_o !== 5'd10) begin bad++; $display("FAIL mid_rst_next_lw got=%0h/%0h/%0d exp=1/11223344/10", wb_valid_o, wb_dmem_rd_data_o, wb_rd_addr_o); end total++;
    go_idle();
  endtask

`ifdef CORE_MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    @(negedge clk_i);
    set_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd4, 1'b1);
    #1;
    if ({dmem_req_o, stall_o} !== 2'b00) begin bad++; $display("FAIL mis_req_stall got=%0b exp=00", {dmem_req_o, stall_o}); end total++;
    @(posedge clk_i); #1;
    if ({wb_valid_o, misalign_o, wb_reg_write_o} !== 3'b110) begin bad++; $display("FAIL mis_wb got=%0b exp=110", {wb_valid_o, misalign_o, wb_reg_write_o}); end total++;
    if (wb_alu_result_o !== 32'h0000_0006) begin bad++; $display("FAIL mis_addr got=%0h exp=6", wb_alu_result_o); end total++;
    go_idle();
    @(posedge clk_i); #1;
    if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%0h exp=0", misalign_o); end total++;
  endtask
`endif

  initial begin
    test_reset();
    test_lb(3'b000, 32'hFFFF_FF80);
    test_lb(3'b100, 32'h0000_0080);
    test_sh_delayed_gnt();
    test_back_to_back();
    test_store_priority_and_sb();
`ifndef CORE_MEM_MISALIGN_TRAP_EN
    test_lh_truncate();
`endif
    test_reset_mid_access();
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
